// File: rtl/rv_multicycle_controller.sv
// Multicycle RV32I control FSM (Moore): one datapath step per clock.
// Optional feature: define ILLEGAL_TRAP_EN to send illegal opcodes to a
// sticky TRAP state and expose the "illegal" output port.
module rv_multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               neg,
  output logic               pcWrite,
  output logic               adrSrc,
  output logic               memWrite,
  output logic               irWrite,
  output logic               regWrite,
  output logic [1:0]         resultSrc,
  output logic [1:0]         aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [2:0]         aluControl,
  output logic [2:0]         immSrc,
  output logic               instr_done,
  output logic [STATE_W-1:0] dbg_state
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               illegal
`endif
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t state, next_state;

  // Ungated enables; reset forces them low below so no partial write lands.
  logic pc_write_c, mem_write_c, ir_write_c, reg_write_c, done_c;

  // funct3 -> ALU operation; sub_en selects subtract for funct3=000.
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_en);
    logic [2:0] res;
    case (f3)
      3'b000:  res = sub_en ? 3'b001 : 3'b000;
      3'b111:  res = 3'b010;
      3'b110:  res = 3'b011;
      3'b100:  res = 3'b100;
      3'b010:  res = 3'b101;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // Branch condition evaluated from the ALU flags of rs1 - rs2.
  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic n);
    logic res;
    case (f3)
      3'b000:  res = z;
      3'b001:  res = ~z;
      3'b100:  res = n;
      3'b101:  res = ~n;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // State register with asynchronous reset back to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and Moore/flag-qualified control outputs.
  always_comb begin
    next_state  = S_FETCH;
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    adrSrc      = 1'b0;
    resultSrc   = 2'b00;
    aluSrcA     = 2'b00;
    aluSrcB     = 2'b00;
    aluControl  = 3'b000;
    immSrc      = 3'b000;
    case (state)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        aluSrcB    = 2'b10;
        resultSrc  = 2'b10;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        immSrc  = (op == OP_JAL) ? 3'b100 : 3'b010;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BR:             next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:           next_state = S_TRAP;
`else
          default:           next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        aluSrcA    = 2'b10;
        aluSrcB    = 2'b01;
        immSrc     = (op == OP_STORE) ? 3'b001 : 3'b000;
        next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc   = 2'b01;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc      = 1'b1;
        mem_write_c = 1'b1;
        done_c      = 1'b1;
        next_state  = S_FETCH;
      end
      S_EXECR: begin
        aluSrcA    = 2'b10;
        aluControl = alu_dec(funct3, funct7b5);
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA    = 2'b10;
        aluSrcB    = 2'b01;
        aluControl = alu_dec(funct3, 1'b0);
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        next_state  = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA    = 2'b10;
        aluControl = 3'b001;
        pc_write_c = br_taken(funct3, zero, neg);
        done_c     = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        pc_write_c = 1'b1;
        aluSrcA    = 2'b01;
        aluSrcB    = 2'b10;
        next_state = S_ALUWB;
      end
      S_JALR: begin
        aluSrcA    = 2'b10;
        aluSrcB    = 2'b01;
        next_state = S_JALR2;
      end
      S_JALR2: begin
        pc_write_c = 1'b1;
        aluSrcA    = 2'b01;
        aluSrcB    = 2'b10;
        next_state = S_ALUWB;
      end
      S_LUI: begin
        aluSrcA    = 2'b11;
        aluSrcB    = 2'b01;
        immSrc     = 3'b011;
        next_state = S_ALUWB;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        next_state = S_TRAP;
`else
        next_state = S_FETCH;
`endif
      end
      default: next_state = S_FETCH;
    endcase
  end

  assign pcWrite    = pc_write_c  & ~rst;
  assign memWrite   = mem_write_c & ~rst;
  assign irWrite    = ir_write_c  & ~rst;
  assign regWrite   = reg_write_c & ~rst;
  assign instr_done = done_c      & ~rst;
  assign dbg_state  = state;
`ifdef ILLEGAL_TRAP_EN
  assign illegal    = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_rv_multicycle_controller.sv
// Self-checking bench: per-instruction expected control sequences built from
// an instruction-level table and compared each cycle against the DUT.
module tb_rv_multicycle_controller;

  typedef logic [21:0] vq_t [$];

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, neg;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, instr_done;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;
  logic [2:0] aluControl, immSrc;
  logic [3:0] dbg_state;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rv_multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .neg(neg), .pcWrite(pcWrite), .adrSrc(adrSrc),
    .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluControl(aluControl), .immSrc(immSrc), .instr_done(instr_done),
    .dbg_state(dbg_state)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  function automatic logic [21:0] mk(input logic [3:0] st, input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, a, b, input logic [2:0] alu, imm,
                                     input logic done);
    return {st, pcw, adr, mw, irw, rw, rs, a, b, alu, imm, done};
  endfunction

  function automatic logic [21:0] observe();
    return {dbg_state, pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc,
            aluSrcA, aluSrcB, aluControl, immSrc, instr_done};
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub_bit);
    case (f3)
      3'd0:    return sub_bit ? 3'd1 : 3'd0;
      3'd7:    return 3'd2;
      3'd6:    return 3'd3;
      3'd4:    return 3'd4;
      3'd2:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return n;
      3'd5:    return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: cycle-by-cycle control outputs of one instruction.
  function automatic vq_t build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic z, input logic n);
    vq_t q;
    logic [21:0] wb;
    wb = mk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1'b1);
    q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0, 1'b0));
    q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'd0,
                   (o == 7'b1101111) ? 3'd4 : 3'd2, 1'b0));
    case (o)
      7'b0000011: begin
        q.push_back(mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'd0, 3'd0, 1'b0));
        q.push_back(mk(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0));
        q.push_back(mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'd0, 3'd0, 1'b1));
      end
      7'b0100011: begin
        q.push_back(mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'd0, 3'd1, 1'b0));
        q.push_back(mk(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1'b1));
      end
      7'b0110011: begin
        q.push_back(mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu_of(f3, f7), 3'd0, 1'b0));
        q.push_back(wb);
      end
      7'b0010011: begin
        q.push_back(mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu_of(f3, 1'b0), 3'd0, 1'b0));
        q.push_back(wb);
      end
      7'b1100011:
        q.push_back(mk(4'd9, taken_of(f3, z, n), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'd1, 3'd0, 1'b1));
      7'b1101111: begin
        q.push_back(mk(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'd0, 3'd0, 1'b0));
        q.push_back(wb);
      end
      7'b1100111: begin
        q.push_back(mk(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'd0, 3'd0, 1'b0));
        q.push_back(mk(4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'd0, 3'd0, 1'b0));
        q.push_back(wb);
      end
      7'b0110111: begin
        q.push_back(mk(4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 3'd0, 3'd3, 1'b0));
        q.push_back(wb);
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        q.push_back(mk(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0));
`endif
      end
    endcase
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z, input logic n);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; neg = n;
  endtask

  task automatic test_reset();
    logic [21:0] rst_vec, fetch_vec, obs;
    rst_vec   = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0, 1'b0);
    fetch_vec = mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0, 1'b0);
    rst = 1'b1;
    set_in(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    obs = observe(); vectors++;
    if (obs !== rst_vec) begin
      errors++; $display("FAIL reset_hold: got %h want %h", obs, rst_vec);
    end
    rst = 1'b0; #1;
    obs = observe(); vectors++;
    if (obs !== fetch_vec) begin
      errors++; $display("FAIL reset_release: got %h want %h", obs, fetch_vec);
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] rst_vec, fetch_vec, obs;
    rst_vec   = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0, 1'b0);
    fetch_vec = mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0, 1'b0);
    set_in(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    vectors++;
    if (dbg_state !== 4'd6) begin
      errors++; $display("FAIL reset_mid_execr: state %0d want 6", dbg_state);
    end
    rst = 1'b1; #1;
    obs = observe(); vectors++;
    if (obs !== rst_vec) begin
      errors++; $display("FAIL reset_mid_async: got %h want %h", obs, rst_vec);
    end
    tick();
    obs = observe(); vectors++;
    if (obs !== rst_vec) begin
      errors++; $display("FAIL reset_mid_hold: got %h want %h", obs, rst_vec);
    end
    rst = 1'b0; #1;
    obs = observe(); vectors++;
    if (obs !== fetch_vec) begin
      errors++; $display("FAIL reset_mid_release: got %h want %h", obs, fetch_vec);
    end
  endtask

  task automatic test_mem();
    vq_t q;
    logic [21:0] obs;
    for (int k = 0; k < 2; k++) begin
      set_in((k == 0) ? 7'b0000011 : 7'b0100011, 3'd2, 1'b1, 1'b1, 1'b1);
      q = build(op, funct3, funct7b5, zero, neg);
      foreach (q[i]) begin
        obs = observe(); vectors++;
        if (obs !== q[i]) begin
          errors++; $display("FAIL mem op=%b step %0d: got %h want %h", op, i, obs, q[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_branch();
    vq_t q;
    logic [21:0] obs;
    logic [2:0] f3s [6] = '{3'd1, 3'd1, 3'd4, 3'd5, 3'd0, 3'd4};
    logic       zs  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       ns  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      set_in(7'b1100011, f3s[k], 1'b0, zs[k], ns[k]);
      q = build(op, funct3, funct7b5, zero, neg);
      foreach (q[i]) begin
        obs = observe(); vectors++;
        if (obs !== q[i]) begin
          errors++; $display("FAIL branch f3=%0d z=%b n=%b step %0d: got %h want %h",
                             funct3, zero, neg, i, obs, q[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_alu_sub();
    logic [6:0] ops [2] = '{7'b0110011, 7'b0010011};
    for (int k = 0; k < 2; k++) begin
      set_in(ops[k], 3'd0, 1'b1, 1'b0, 1'b0);
      tick(); tick();
      vectors++;
      if (aluControl !== ((k == 0) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL alu_sub op=%b: got %0d want %0d", op, aluControl, (k == 0) ? 1 : 0);
      end
      tick(); tick();
    end
  endtask

  task automatic test_jumps();
    vq_t q;
    logic [21:0] obs;
    logic [6:0] ops [3] = '{7'b1101111, 7'b1100111, 7'b0110111};
    for (int k = 0; k < 3; k++) begin
      set_in(ops[k], 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
      q = build(op, funct3, funct7b5, zero, neg);
      foreach (q[i]) begin
        obs = observe(); vectors++;
        if (obs !== q[i]) begin
          errors++; $display("FAIL jump op=%b step %0d: got %h want %h", op, i, obs, q[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_illegal();
    vq_t q;
    logic [21:0] obs, fetch_vec;
    fetch_vec = mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0, 1'b0);
    set_in(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0);
    q = build(op, funct3, funct7b5, zero, neg);
    foreach (q[i]) begin
      obs = observe(); vectors++;
      if (obs !== q[i]) begin
        errors++; $display("FAIL illegal step %0d: got %h want %h", i, obs, q[i]);
      end
      if (i < q.size() - 1) tick();
    end
`ifdef ILLEGAL_TRAP_EN
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (dbg_state !== 4'd14 || illegal !== 1'b1 || pcWrite !== 1'b0 || irWrite !== 1'b0) begin
        errors++; $display("FAIL trap_hold: state %0d illegal %b want 14/1", dbg_state, illegal);
      end
    end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    vectors++;
    if (illegal !== 1'b0 || dbg_state !== 4'd0) begin
      errors++; $display("FAIL trap_exit: state %0d illegal %b want 0/0", dbg_state, illegal);
    end
`else
    tick();
    obs = observe(); vectors++;
    if (obs !== fetch_vec) begin
      errors++; $display("FAIL illegal_nop_return: got %h want %h", obs, fetch_vec);
    end
`endif
  endtask

  task automatic test_random();
    vq_t q;
    logic [21:0] obs;
    logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0110011};
    for (int k = 0; k < 150; k++) begin
      set_in(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom),
             1'($urandom), 1'($urandom));
      q = build(op, funct3, funct7b5, zero, neg);
      foreach (q[i]) begin
        obs = observe(); vectors++;
        if (obs !== q[i]) begin
          errors++; $display("FAIL random op=%b f3=%0d step %0d: got %h want %h",
                             op, funct3, i, obs, q[i]);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_mem();
    test_branch();
    test_alu_sub();
    test_jumps();
    test_reset_mid();
    test_random();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_controller.md
Name: rv_multicycle_controller

Overview:
- Moore FSM sequencing the multicycle RV32I datapath: PC/IR registers, register file, shared ALU, unified memory, immediate extend unit.
- Consumes opcode/funct fields from the IR plus ALU flags; emits all mux selects, write enables, ALU op and the 3-bit immSrc code for the extend unit, one datapath step per clock.
- Supported: add/sub/and/or/xor/slt, addi/andi/ori/xori/slti, lw, sw, beq/bne/blt/bge, jal, jalr, lui.

Parameters:
- STATE_W, 4, width of state register and dbg_state port.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU result == 0
- neg  in  1  ALU signed-less-than flag (sign of rs1-rs2, overflow-corrected)
- pcWrite  out  1  PC load enable
- adrSrc  out  1  0 = PC, 1 = aluOut as memory address
- memWrite  out  1  memory write enable
- irWrite  out  1  IR and oldPC load enable
- regWrite  out  1  register-file write enable
- resultSrc  out  2  00 aluOut, 01 memData, 10 ALU result (combinational)
- aluSrcA  out  2  00 PC, 01 oldPC, 10 rs1 reg, 11 zero
- aluSrcB  out  2  00 rs2 reg, 01 immExt, 10 constant 4
- aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- immSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- dbg_state  out  STATE_W  current state encoding

Behaviour:
- Reset: state <= FETCH asynchronously. While rst=1, pcWrite/irWrite/regWrite/memWrite/instr_done = 0; selects show FETCH values. First FETCH occurs on the first rising edge after rst falls.
- Outputs are combinational from state, plus op/funct3/funct7b5/zero/neg where noted. Unlisted enables = 0; unlisted selects = 00/000.
- FETCH(0): adrSrc=0, irWrite=1, A=00, B=10, add, resultSrc=10, pcWrite=1 -> DECODE.
- DECODE(1): A=01, B=01, add (precompute target into aluOut); immSrc=100 if op=jal, else 010. Next state by op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - other -> illegal handling (see Optional Feature)
- MEMADR(2): A=10, B=01, add; immSrc=000 for lw, 001 for sw. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD(3): adrSrc=1 -> MEMWB.
- MEMWB(4): resultSrc=01, regWrite=1, instr_done=1 -> FETCH.
- MEMWRITE(5): adrSrc=1, memWrite=1, instr_done=1 -> FETCH.
- EXECR(6): A=10, B=00; ALU op by funct3: 000 add (sub when funct7b5=1), 111 and, 110 or, 100 xor, 010 slt -> ALUWB.
- EXECI(7): A=10, B=01, immSrc=000; same funct3 map; funct7b5 ignored (always add for 000) -> ALUWB.
- ALUWB(8): resultSrc=00, regWrite=1, instr_done=1 -> FETCH.
- BRANCH(9): A=10, B=00, sub, resultSrc=00, instr_done=1 -> FETCH. pcWrite = taken, where taken = beq:zero, bne:~zero, blt:neg, bge:~neg; other funct3 -> not taken.
- JAL(10): resultSrc=00, pcWrite=1 (PC<=target); concurrently A=01, B=10, add (oldPC+4 into aluOut) -> ALUWB.
- JALR(11): A=10, B=01, immSrc=000, add -> JALR2.
- JALR2(12): resultSrc=00, pcWrite=1; A=01, B=10, add -> ALUWB. Target bit0 is not cleared (datapath responsibility).
- LUI(13): A=11, B=01, immSrc=011, add -> ALUWB.
- Latencies (FETCH to done): lw 5, sw 4, R/I/lui 4, branch 3, jal 4, jalr 5 cycles.
- Unused encodings 14/15 -> FETCH with no enables asserted.
- Reset mid-instruction: write enables drop immediately; no partial write completes.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: illegal op in DECODE -> TRAP(14). TRAP asserts all enables 0 and holds until rst. An extra output port illegal (1 bit) is 1 in TRAP, 0 otherwise.
- Undefined: illegal op in DECODE -> FETCH (2-cycle NOP, instr_done not pulsed); port illegal absent.

Test Plan:
- Reset: rst=1 mid-EXECR -> dbg_state=0 same cycle, all enables 0; rst=0 -> next edge irWrite=1, pcWrite=1.
- lw (op=0000011) -> states 0,1,2,3,4; immSrc=000 in MEMADR; regWrite=1 with resultSrc=01 only in cycle 5.
- sw (op=0100011) -> immSrc=001 in MEMADR; memWrite=1, adrSrc=1 in cycle 4; regWrite never 1.
- bne funct3=001: zero=1 -> pcWrite=0 in BRANCH; zero=0 -> pcWrite=1. blt neg=1 -> pcWrite=1; bge neg=1 -> 0.
- R-type funct3=000 funct7b5=1 -> aluControl=001 in EXECR. Same bits on addi (op=0010011) -> 000.
- jal -> immSrc=100 in DECODE, pcWrite in JAL, regWrite in ALUWB. jalr -> 0,1,11,12,8. Op 1111111: trap with macro defined (illegal=1), else return to FETCH.
